// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: length codes, byte counts and the queued entry.
package store_buffer_pkg;

  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  typedef struct packed {
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] data;
  } stb_entry_t;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      LEN_WORD: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

  // Exclusive end of an access in 33 bits so address+n never wraps.
  function automatic logic [32:0] stb_end(input logic [31:0] addr, input logic [1:0] len);
    return {1'b0, addr} + {30'd0, len_bytes(len)};
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store, load and memory-port signals of the store buffer; slave is the buffer side.
interface store_buffer_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ST_valid;
  logic          ST_ready;
  logic [1:0]    ST_length;
  logic [31:0]   ST_address;
  logic [31:0]   ST_data;
  logic          LD_valid;
  logic [1:0]    LD_length;
  logic          LD_signed;
  logic [31:0]   LD_address;
  logic          LD_hazard;
  logic          MEM_write_ready;
  logic [1:0]    MEM_write_length;
  logic [31:0]   MEM_write_address;
  logic [31:0]   MEM_write_data;
  logic [1:0]    MEM_read_length;
  logic          MEM_read_signed;
  logic [31:0]   MEM_read_address;
  logic          STB_empty;
  logic [CW-1:0] STB_count;
  logic          ERR_range;

  modport master (
    output ST_valid, ST_length, ST_address, ST_data,
    output LD_valid, LD_length, LD_signed, LD_address,
    output MEM_write_ready,
    input  ST_ready, LD_hazard,
    input  MEM_write_length, MEM_write_address, MEM_write_data,
    input  MEM_read_length, MEM_read_signed, MEM_read_address,
    input  STB_empty, STB_count, ERR_range
  );

  modport slave (
    input  ST_valid, ST_length, ST_address, ST_data,
    input  LD_valid, LD_length, LD_signed, LD_address,
    input  MEM_write_ready,
    output ST_ready, LD_hazard,
    output MEM_write_length, MEM_write_address, MEM_write_data,
    output MEM_read_length, MEM_read_signed, MEM_read_address,
    output STB_empty, STB_count, ERR_range
  );
endinterface

// File: rtl/store_buffer_overlap.sv
// Combinational byte-range intersect of one queued store against the current load.
module stb_overlap
  import store_buffer_pkg::*;
(
  input  logic        ent_vld,
  input  logic [1:0]  ent_len,
  input  logic [31:0] ent_addr,
  input  logic [1:0]  ld_len,
  input  logic [31:0] ld_addr,
  output logic        hit
);
  // A zero-length load covers no bytes, so it can never overlap.
  assign hit = ent_vld && (ld_len != LEN_NONE)
            && ({1'b0, ld_addr}  < stb_end(ent_addr, ent_len))
            && ({1'b0, ent_addr} < stb_end(ld_addr, ld_len));
endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO in front of the data memory write port, with load/store hazard detection.
// Optional bounds check on stores and loads enabled by STORE_BUFFER_BOUNDS_CHECK_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MEM_BYTES = 100
) (
  input  logic          SYS_clk,
  input  logic          SYS_reset,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef STORE_BUFFER_BOUNDS_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  stb_entry_t       ent_q [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;
  logic [DEPTH-1:0] ent_vld, hit;
  logic             st_ok, ld_ok, st_acc, push, pop, ld_issue, head_vld;

  assign st_ok = !CHK_EN || (stb_end(bus.ST_address, bus.ST_length) <= 33'(MEM_BYTES));
  assign ld_ok = !CHK_EN || (stb_end(bus.LD_address, bus.LD_length) <= 33'(MEM_BYTES));

  assign bus.ST_ready = (cnt != CW'(DEPTH));
  assign st_acc       = bus.ST_valid && bus.ST_ready && (bus.ST_length != LEN_NONE) && !SYS_reset;
  assign push         = st_acc && st_ok;

  // Loads that actually go to memory win the port arbitration over draining.
  assign ld_issue = bus.LD_valid && ld_ok && !bus.LD_hazard;
  assign pop      = (cnt != '0) && bus.MEM_write_ready && !ld_issue;

`ifdef STORE_BUFFER_BOUNDS_CHECK_EN
  assign bus.ERR_range = st_acc && !st_ok;
`else
  assign bus.ERR_range = 1'b0;
`endif

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      logic [PW-1:0] off;
      // Slot is live when its distance from the head is below the occupancy.
      assign off        = PW'(g) - rd_ptr;
      assign ent_vld[g] = ({1'b0, off} < cnt);
      stb_overlap u_ovl (
        .ent_vld  (ent_vld[g]),
        .ent_len  (ent_q[g].len),
        .ent_addr (ent_q[g].addr),
        .ld_len   (bus.LD_length),
        .ld_addr  (bus.LD_address),
        .hit      (hit[g])
      );
    end
  endgenerate

  assign bus.LD_hazard        = bus.LD_valid && ld_ok && (|hit);
  assign bus.MEM_read_length  = (bus.LD_valid && ld_ok) ? bus.LD_length : LEN_NONE;
  assign bus.MEM_read_signed  = bus.LD_signed;
  assign bus.MEM_read_address = bus.LD_address;

  assign head_vld              = (cnt != '0) && !SYS_reset;
  assign bus.MEM_write_length  = head_vld ? ent_q[rd_ptr].len  : LEN_NONE;
  assign bus.MEM_write_address = head_vld ? ent_q[rd_ptr].addr : 32'd0;
  assign bus.MEM_write_data    = head_vld ? ent_q[rd_ptr].data : 32'd0;

  assign bus.STB_empty = (cnt == '0);
  assign bus.STB_count = cnt;

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (push) ent_q[wr_ptr] <= '{len: bus.ST_length, addr: bus.ST_address, data: bus.ST_data};
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the execute/memory stage and the byte-addressed data memory. Stores are accepted in one cycle, queued in a FIFO of DEPTH entries and drained to the memory write port in program order whenever the port is free. Loads pass straight through to the memory read port; any load whose bytes overlap a queued store raises a hazard so the pipeline stalls until that store has drained.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- MEM_BYTES, 100: data memory size in bytes; used by the bounds check.
- SYS_clk  in  1  clock; all state updates on rising edge.
- SYS_reset  in  1  synchronous, active-high reset.
- ST_valid  in  1  store request.
- ST_ready  out  1  buffer can accept a store this cycle.
- ST_length  in  2  01 byte, 10 half, 11 word; 00 means no store.
- ST_address  in  32  byte address of the first (most significant) byte.
- ST_data  in  32  store data, right-justified.
- LD_valid  in  1  load request.
- LD_length  in  2  load length, same encoding as ST_length.
- LD_signed  in  1  sign-extend the load.
- LD_address  in  32  load byte address.
- LD_hazard  out  1  load overlaps a queued store; the requester must hold the load.
- MEM_write_ready  in  1  memory write port can accept a write this cycle.
- MEM_write_length  out  2  write length to memory; 00 when idle.
- MEM_write_address  out  32  write address to memory.
- MEM_write_data  out  32  write data to memory.
- MEM_read_length  out  2  pass-through of LD_length; 00 when LD_valid=0.
- MEM_read_signed  out  1  pass-through of LD_signed.
- MEM_read_address  out  32  pass-through of LD_address.
- STB_empty  out  1  no entries queued.
- STB_count  out  $clog2(DEPTH)+1  number of occupied entries.
- ERR_range  out  1  one-cycle pulse when an out-of-range store is dropped (only with the macro).

## Operation
- Push happens when ST_valid & ST_ready & ST_length≠00. The entry {length, address, data} is written at the tail. ST_length=00 with ST_valid is accepted and discarded.
- ST_ready = (count≠DEPTH). A pop in the same cycle does not make a full buffer ready.
- The head entry drives MEM_write_* combinationally whenever count≠0; otherwise MEM_write_length=00 and address/data are 0.
- Pop happens when count≠0 & MEM_write_ready & !(LD_valid & !LD_hazard). Loads that go to memory take priority over draining.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count ranges 0..DEPTH.
- Overlap test per valid entry: byte ranges [A, A+n) intersect, where n = 1, 2 or 4 from the length code. Compare in 33-bit arithmetic so A+n cannot wrap.
- LD_hazard = LD_valid & OR over valid entries of overlap. A store pushed in the current cycle is not yet visible to the overlap test.
- Byte order is big-endian:
  - word store: address+0 receives data[31:24].
  - half store: address+0 receives data[15:8].
  - The buffer does not reorder bytes; it forwards ST_data unchanged.
- The buffer never merges stores.

## Timing
- Store acceptance: zero-latency handshake.
- The earliest memory write for a store is the cycle after it is accepted (the head becomes valid on the next edge).
- LD_hazard and MEM_read_* are purely combinational from the LD_* inputs and the current state.
- Reset values: count=0, pointers=0, STB_empty=1, ST_ready=1, MEM_write_length=00, ERR_range=0.
- Reset in mid-operation discards all queued stores; nothing reaches memory in the reset cycle (MEM_write_length=00).
- An asserted MEM_write_ready with an empty buffer is ignored.

## Configuration
- Macro: STORE_BUFFER_BOUNDS_CHECK_EN.
  - Defined: a store with address+n > MEM_BYTES is acknowledged (ST_ready handshake completes), not queued, and ERR_range pulses high for exactly that cycle. A load with address+n > MEM_BYTES forces MEM_read_length=00 and LD_hazard=0.
  - Undefined: no checks; ERR_range is tied to 0; all addresses pass through.

## Structure
- Shared package holds:
  - length codes LEN_NONE=00, LEN_BYTE=01, LEN_HALF=10, LEN_WORD=11;
  - a function mapping a length code to its byte count;
  - the entry struct {len[1:0], addr[31:0], data[31:0]}.
- One sub-module, stb_overlap: combinational range-intersect of one entry against the load, instantiated DEPTH times.

## Test plan
- Reset, then a word store to 0x10 with data 0xDEADBEEF and MEM_write_ready=1 → next cycle MEM_write_length=11, address 0x10, data 0xDEADBEEF; the cycle after that STB_empty=1.
- MEM_write_ready=0, then 5 byte stores to 0x00..0x04 → the first 4 are accepted, ST_ready=0 on the 5th, STB_count=4; raising ready drains them in order 0x00, 0x01, 0x02, 0x03.
- Half store to 0x21 queued, then a load of a byte at 0x22 → LD_hazard=1 until the store drains. A load of a byte at 0x23 → LD_hazard=0 with MEM_read_address=0x23.
- With count=4, ST_valid=1 and a drain in the same cycle → the store is not accepted and count becomes 3; the next cycle the store is accepted.
- Reset asserted with 3 stores queued → STB_count=0 on the next cycle and no MEM write is observed.
- With the macro defined, a word store to 98 → ERR_range pulses, the store is not queued, and count is unchanged.
